// File: rtl/ice_target.sv
// ice_target: core-side responder for the ICE bus.
//
// Decodes 8-bit commands from the ice serial bridge and services them:
// address/count setup, VRAM peek/poke/fill through an arbitrated VRAM
// port, switch readback and a CPU halt request.
//
// Optional feature macro: ICE_FILL_EN
//   defined   -> SET_COUNT (0x05) and FILL (0x04) are implemented
//   undefined -> 0x04/0x05 are illegal, no count register is built
//
// Ports:
//   CLK                   clock (CLK_CPU domain)
//   I_RESET               synchronous active-high reset
//   I_ICE_BUS_CMD[7:0]    bit 7 command toggle, bits 6:0 opcode
//   I_ICE_BUS_FROMICE[15:0] command operand
//   O_ICE_BUS_RESP[7:0]   bit 7 ack toggle, bit 6 error, bit 5 halted
//   O_ICE_BUS_TOICE[15:0] read data (PEEK / READ_SW)
//   I_SW[3:0]             board switches
//   O_HALT                CPU halt request
//   O_VBUS_REQ / I_VBUS_GNT  VRAM port request / grant
//   O_VBUS_ADDR, O_VBUS_WE, O_VBUS_DATA_TOVRAM  VRAM access
//   I_VBUS_DATA_FROMVRAM  VRAM read data, valid one cycle after address
module ice_target #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 3
) (
  input  logic              CLK,
  input  logic              I_RESET,
  input  logic [7:0]        I_ICE_BUS_CMD,
  input  logic [15:0]       I_ICE_BUS_FROMICE,
  output logic [7:0]        O_ICE_BUS_RESP,
  output logic [15:0]       O_ICE_BUS_TOICE,
  input  logic [3:0]        I_SW,
  output logic              O_HALT,
  output logic              O_VBUS_REQ,
  input  logic              I_VBUS_GNT,
  output logic [ADDR_W-1:0] O_VBUS_ADDR,
  output logic              O_VBUS_WE,
  output logic [DATA_W-1:0] O_VBUS_DATA_TOVRAM,
  input  logic [DATA_W-1:0] I_VBUS_DATA_FROMVRAM
);

  localparam logic [6:0] OP_NOP      = 7'h00;
  localparam logic [6:0] OP_SET_ADDR = 7'h01;
  localparam logic [6:0] OP_PEEK     = 7'h02;
  localparam logic [6:0] OP_POKE     = 7'h03;
  localparam logic [6:0] OP_READ_SW  = 7'h06;
  localparam logic [6:0] OP_HALT     = 7'h07;
`ifdef ICE_FILL_EN
  localparam logic [6:0] OP_FILL      = 7'h04;
  localparam logic [6:0] OP_SET_COUNT = 7'h05;
`endif

  typedef enum logic [1:0] {IDLE, WAIT_GNT, ACCESS, CAPTURE} state_t;

  state_t              state, state_next;
  logic [6:0]          op_q;
  logic [DATA_W-1:0]   operand_q;
  logic [ADDR_W-1:0]   addr;
  logic [15:0]         toice;
  logic                ack, err, halt;
  logic                pending, complete, complete_err, is_write;
  logic [6:0]          opcode;
`ifdef ICE_FILL_EN
  logic [15:0]         count;
  logic [15:0]         remaining;
`endif

  assign opcode  = I_ICE_BUS_CMD[6:0];
  // A new command exists when the toggle differs from the last ack we sent.
  assign pending = (state == IDLE) && (I_ICE_BUS_CMD[7] != ack);

  always_comb begin
    is_write = (op_q == OP_POKE);
`ifdef ICE_FILL_EN
    is_write = is_write || (op_q == OP_FILL);
`endif
  end

  // Next-state logic; 'complete' marks the edge on which the ack toggles.
  always_comb begin
    state_next   = state;
    complete     = 1'b0;
    complete_err = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          case (opcode)
            OP_NOP, OP_SET_ADDR, OP_READ_SW, OP_HALT: complete = 1'b1;
            OP_PEEK, OP_POKE: state_next = WAIT_GNT;
`ifdef ICE_FILL_EN
            OP_SET_COUNT: complete = 1'b1;
            // An empty fill never touches the bus.
            OP_FILL: begin
              if (count == 16'd0) complete = 1'b1;
              else state_next = WAIT_GNT;
            end
`endif
            default: begin
              complete     = 1'b1;
              complete_err = 1'b1;
            end
          endcase
        end
      end
      WAIT_GNT: begin
        if (I_VBUS_GNT) state_next = ACCESS;
      end
      ACCESS: begin
        // Losing the grant holds address/count and re-arbitrates.
        if (!I_VBUS_GNT) begin
          state_next = WAIT_GNT;
        end else if (op_q == OP_PEEK) begin
          state_next = CAPTURE;
`ifdef ICE_FILL_EN
        end else if (op_q == OP_FILL) begin
          if (remaining == 16'd1) begin
            state_next = IDLE;
            complete   = 1'b1;
          end
`endif
        end else begin
          state_next = IDLE;
          complete   = 1'b1;
        end
      end
      CAPTURE: begin
        state_next = IDLE;
        complete   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (I_RESET) state <= IDLE;
    else         state <= state_next;
  end

  // Datapath: operand latching at detect, address/count stepping on writes,
  // read capture, and the ack/error/halt status register.
  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      op_q      <= OP_NOP;
      operand_q <= '0;
      addr      <= '0;
      toice     <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      halt      <= 1'b0;
`ifdef ICE_FILL_EN
      count     <= '0;
      remaining <= '0;
`endif
    end else begin
      if (complete) begin
        ack <= ~ack;
        err <= complete_err;
      end
      case (state)
        IDLE: begin
          if (pending) begin
            op_q      <= opcode;
            operand_q <= I_ICE_BUS_FROMICE[DATA_W-1:0];
            case (opcode)
              OP_SET_ADDR:  addr  <= I_ICE_BUS_FROMICE[ADDR_W-1:0];
              OP_READ_SW:   toice <= {12'b0, I_SW};
              OP_HALT:      halt  <= I_ICE_BUS_FROMICE[0];
`ifdef ICE_FILL_EN
              OP_SET_COUNT: count     <= I_ICE_BUS_FROMICE;
              OP_FILL:      remaining <= count;
`endif
              default: ;
            endcase
          end
        end
        ACCESS: begin
          if (I_VBUS_GNT && is_write) begin
            addr <= addr + ADDR_W'(1);
`ifdef ICE_FILL_EN
            if (op_q == OP_FILL) remaining <= remaining - 16'd1;
`endif
          end
        end
        CAPTURE: begin
          toice <= 16'(I_VBUS_DATA_FROMVRAM);
          addr  <= addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign O_ICE_BUS_RESP     = {ack, err, halt, 5'b0};
  assign O_ICE_BUS_TOICE    = toice;
  assign O_HALT             = halt;
  assign O_VBUS_REQ         = (state != IDLE);
  assign O_VBUS_ADDR        = addr;
  assign O_VBUS_WE          = (state == ACCESS) && I_VBUS_GNT && is_write;
  assign O_VBUS_DATA_TOVRAM = operand_q;

endmodule

// File: tb/tb_ice_target.sv
// tb_ice_target: self-checking bench for ice_target.
// Expected VRAM writes are pushed to a scoreboard queue when a command is
// issued and popped against the writes the DUT actually performs.
// FILL scenarios run when ICE_FILL_EN is defined; otherwise opcodes
// 0x04/0x05 are checked to be illegal.
module tb_ice_target;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cmd;
  logic [15:0] fromice;
  logic [7:0]  resp;
  logic [15:0] toice;
  logic [3:0]  sw;
  logic        halt, req, gnt, we;
  logic [15:0] vaddr;
  logic [2:0]  wdata, rdata;

  ice_target #(.ADDR_W(16), .DATA_W(3)) dut (
    .CLK(clk), .I_RESET(reset),
    .I_ICE_BUS_CMD(cmd), .I_ICE_BUS_FROMICE(fromice),
    .O_ICE_BUS_RESP(resp), .O_ICE_BUS_TOICE(toice),
    .I_SW(sw), .O_HALT(halt),
    .O_VBUS_REQ(req), .I_VBUS_GNT(gnt),
    .O_VBUS_ADDR(vaddr), .O_VBUS_WE(we),
    .O_VBUS_DATA_TOVRAM(wdata), .I_VBUS_DATA_FROMVRAM(rdata)
  );

  always #5 clk = ~clk;

  // Environment VRAM: synchronous write, registered read.
  logic [2:0] vram [65536];
  always @(posedge clk) begin
    if (we) vram[vaddr] <= wdata;
    rdata <= vram[vaddr];
  end

  // Reference model state.
  logic [2:0]  mem_m [65536];
  logic [15:0] addr_m;
  logic [15:0] count_m;

  int errors = 0;
  int checks = 0;

  logic        toggle;
  int          lat;
  logic        req_any, req_c1, req_ack;
  logic [15:0] addr_c2;
  int          we_bad;
  logic [15:0] wr_addr [$];
  logic [2:0]  wr_data [$];
  int          wr_cyc  [$];
  logic [15:0] exp_addr [$];
  logic [2:0]  exp_data [$];
  logic [15:0] ea, ga;
  logic [2:0]  ed, gd;

  function automatic logic [2:0] pat(input int a);
    logic [15:0] v;
    v = 16'(a);
    return v[2:0] ^ v[5:3];
  endfunction

  // Issue one command and follow it to its ack, logging bus activity.
  // GNT is low for cycles [low_start, low_start+low_len) after detect.
  task automatic run_cmd(input logic [6:0] op, input logic [15:0] operand,
                         input int low_start, input int low_len);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    @(negedge clk);
    toggle  = ~toggle;
    cmd     = {toggle, op};
    fromice = operand;
    gnt     = 1'b1;
    lat = -1; req_any = 1'b0; req_c1 = 1'b0; req_ack = 1'b1;
    addr_c2 = 16'hxxxx; we_bad = 0;
    if (req) req_any = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      fromice = ~operand;
      gnt = !(cyc >= low_start && cyc < low_start + low_len);
      @(negedge clk);
      if (req) req_any = 1'b1;
      if (cyc == 1) req_c1 = req;
      if (cyc == 2) addr_c2 = vaddr;
      if (we) begin
        wr_addr.push_back(vaddr); wr_data.push_back(wdata); wr_cyc.push_back(cyc);
        if (!gnt) we_bad++;
      end
      if (resp[7] == toggle) begin
        lat = cyc;
        req_ack = req;
        break;
      end
    end
    gnt = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd = 8'h00; fromice = 16'h0; sw = 4'h0; gnt = 1'b1;
    toggle = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (resp !== 8'h00) begin errors++; $display("[TB] FAIL reset_resp: got %h expected 00", resp); end
    checks++; if (req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", req); end
    checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", we); end
    checks++; if (toice !== 16'h0) begin errors++; $display("[TB] FAIL reset_toice: got %h expected 0000", toice); end
    checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt: got %b expected 0", halt); end
    reset = 1'b0;
    addr_m = 16'h0; count_m = 16'h0;
  endtask

  task automatic test_set_addr_peek();
    run_cmd(7'h01, 16'h1234, 0, 0);
    addr_m = 16'h1234;
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL set_addr_latency: got %0d expected 1", lat); end
    checks++; if (resp !== 8'h80) begin errors++; $display("[TB] FAIL set_addr_resp: got %h expected 80", resp); end
    run_cmd(7'h02, 16'h0, 0, 0);
    checks++; if (addr_c2 !== 16'h1234) begin errors++; $display("[TB] FAIL peek_addr: got %h expected 1234", addr_c2); end
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL peek_latency: got %0d expected 4", lat); end
    checks++; if (toice !== {13'b0, mem_m[16'h1234]}) begin errors++; $display("[TB] FAIL peek_data: got %h expected %h", toice, {13'b0, mem_m[16'h1234]}); end
    addr_m = addr_m + 16'd1;
  endtask

  task automatic test_poke_peek();
    run_cmd(7'h01, 16'h0010, 0, 0);
    addr_m = 16'h0010;
    exp_addr.push_back(addr_m); exp_data.push_back(3'd5);
    mem_m[addr_m] = 3'd5; addr_m = addr_m + 16'd1;
    run_cmd(7'h03, 16'h0005, 0, 0);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL poke_latency: got %0d expected 3", lat); end
    checks++; if (req_c1 !== 1'b1) begin errors++; $display("[TB] FAIL poke_req_c1: got %b expected 1", req_c1); end
    checks++; if (req_ack !== 1'b0) begin errors++; $display("[TB] FAIL poke_req_at_ack: got %b expected 0", req_ack); end
    checks++; if (wr_cyc.size() == 0 || wr_cyc[0] != 2) begin errors++; $display("[TB] FAIL poke_we_cycle: got %0d writes expected one at c2", wr_cyc.size()); end
    while (exp_addr.size() > 0) begin
      ea = exp_addr.pop_front(); ed = exp_data.pop_front();
      checks++;
      if (wr_addr.size() == 0) begin errors++; $display("[TB] FAIL poke_write: got none expected %h=%0d", ea, ed); end
      else begin
        ga = wr_addr.pop_front(); gd = wr_data.pop_front();
        if (ga !== ea || gd !== ed) begin errors++; $display("[TB] FAIL poke_write: got %h=%0d expected %h=%0d", ga, gd, ea, ed); end
      end
    end
    checks++; if (wr_addr.size() != 0) begin errors++; $display("[TB] FAIL poke_extra_writes: got %0d extra expected 0", wr_addr.size()); end
    run_cmd(7'h01, 16'h0010, 0, 0);
    addr_m = 16'h0010;
    run_cmd(7'h02, 16'h0, 0, 0);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL poke_peek_latency: got %0d expected 4", lat); end
    checks++; if (toice !== 16'h0005) begin errors++; $display("[TB] FAIL poke_peek_data: got %h expected 0005", toice); end
    addr_m = addr_m + 16'd1;
  endtask

`ifdef ICE_FILL_EN
  task automatic test_fill_wrap();
    run_cmd(7'h01, 16'hFFFE, 0, 0); addr_m = 16'hFFFE;
    run_cmd(7'h05, 16'd4, 0, 0);    count_m = 16'd4;
    for (int i = 0; i < int'(count_m); i++) begin
      exp_addr.push_back(addr_m); exp_data.push_back(3'd3);
      mem_m[addr_m] = 3'd3; addr_m = addr_m + 16'd1;
    end
    run_cmd(7'h04, 16'h0003, 0, 0);
    checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL fill_latency: got %0d expected 6", lat); end
    checks++; if (wr_cyc.size() != 4 || wr_cyc[0] != 2 || wr_cyc[3] != 5) begin errors++; $display("[TB] FAIL fill_we_run: got %0d writes expected 4 at c2..c5", wr_cyc.size()); end
    while (exp_addr.size() > 0) begin
      ea = exp_addr.pop_front(); ed = exp_data.pop_front();
      checks++;
      if (wr_addr.size() == 0) begin errors++; $display("[TB] FAIL fill_write: got none expected %h=%0d", ea, ed); end
      else begin
        ga = wr_addr.pop_front(); gd = wr_data.pop_front();
        if (ga !== ea || gd !== ed) begin errors++; $display("[TB] FAIL fill_write: got %h=%0d expected %h=%0d", ga, gd, ea, ed); end
      end
    end
    checks++; if (wr_addr.size() != 0) begin errors++; $display("[TB] FAIL fill_extra_writes: got %0d extra expected 0", wr_addr.size()); end
    run_cmd(7'h02, 16'h0, 0, 0);
    checks++; if (addr_c2 !== 16'h0002) begin errors++; $display("[TB] FAIL fill_end_addr: got %h expected 0002", addr_c2); end
    addr_m = addr_m + 16'd1;
    run_cmd(7'h05, 16'd0, 0, 0); count_m = 16'd0;
    run_cmd(7'h04, 16'h0007, 0, 0);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL fill0_latency: got %0d expected 1", lat); end
    checks++; if (req_any !== 1'b0) begin errors++; $display("[TB] FAIL fill0_req: got %b expected 0", req_any); end
  endtask

  // A grant drop while waiting costs exactly its length; a drop during
  // ACCESS also costs the cycle spent re-entering ACCESS from WAIT_GNT.
  task automatic test_grant_loss(input int low_start, input int extra);
    run_cmd(7'h01, 16'h0100, 0, 0); addr_m = 16'h0100;
    run_cmd(7'h05, 16'd8, 0, 0);    count_m = 16'd8;
    for (int i = 0; i < int'(count_m); i++) begin
      exp_addr.push_back(addr_m); exp_data.push_back(3'd6);
      mem_m[addr_m] = 3'd6; addr_m = addr_m + 16'd1;
    end
    run_cmd(7'h04, 16'h0006, low_start, 5);
    checks++; if (lat !== 10 + extra) begin errors++; $display("[TB] FAIL gnt_loss_latency: got %0d expected %0d", lat, 10 + extra); end
    checks++; if (we_bad !== 0) begin errors++; $display("[TB] FAIL gnt_loss_we_low: got %0d writes without grant expected 0", we_bad); end
    while (exp_addr.size() > 0) begin
      ea = exp_addr.pop_front(); ed = exp_data.pop_front();
      checks++;
      if (wr_addr.size() == 0) begin errors++; $display("[TB] FAIL gnt_loss_write: got none expected %h=%0d", ea, ed); end
      else begin
        ga = wr_addr.pop_front(); gd = wr_data.pop_front();
        if (ga !== ea || gd !== ed) begin errors++; $display("[TB] FAIL gnt_loss_write: got %h=%0d expected %h=%0d", ga, gd, ea, ed); end
      end
    end
    checks++; if (wr_addr.size() != 0) begin errors++; $display("[TB] FAIL gnt_loss_extra_writes: got %0d extra expected 0", wr_addr.size()); end
  endtask
`else
  task automatic test_fill_disabled();
    run_cmd(7'h05, 16'd4, 0, 0);
    checks++; if (resp[6] !== 1'b1 || lat !== 1) begin errors++; $display("[TB] FAIL set_count_illegal: got err=%b lat=%0d expected err=1 lat=1", resp[6], lat); end
    run_cmd(7'h04, 16'h0003, 0, 0);
    checks++; if (resp[6] !== 1'b1 || lat !== 1) begin errors++; $display("[TB] FAIL fill_illegal: got err=%b lat=%0d expected err=1 lat=1", resp[6], lat); end
    checks++; if (req_any !== 1'b0) begin errors++; $display("[TB] FAIL fill_illegal_req: got %b expected 0", req_any); end
  endtask
`endif

  task automatic test_illegal();
    run_cmd(7'h7F, 16'h0, 0, 0);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL illegal_latency: got %0d expected 1", lat); end
    checks++; if (resp[6] !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err: got %b expected 1", resp[6]); end
    checks++; if (req_any !== 1'b0) begin errors++; $display("[TB] FAIL illegal_req: got %b expected 0", req_any); end
    run_cmd(7'h00, 16'h0, 0, 0);
    checks++; if (resp[6] !== 1'b0) begin errors++; $display("[TB] FAIL nop_clears_err: got %b expected 0", resp[6]); end
  endtask

  task automatic test_halt();
    run_cmd(7'h07, 16'h0001, 0, 0);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL halt_latency: got %0d expected 1", lat); end
    checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL halt_out: got %b expected 1", halt); end
    checks++; if (resp[5] !== 1'b1) begin errors++; $display("[TB] FAIL halt_resp: got %b expected 1", resp[5]); end
  endtask

  task automatic test_reset_mid_op();
    run_cmd(7'h01, 16'h0200, 0, 0);
    @(negedge clk);
    toggle = ~toggle;
`ifdef ICE_FILL_EN
    run_cmd(7'h05, 16'd8, 0, 0);
    @(negedge clk);
    toggle = ~toggle;
    cmd = {toggle, 7'h04}; fromice = 16'h0001; gnt = 1'b1;
`else
    cmd = {toggle, 7'h02}; fromice = 16'h0; gnt = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("[TB] FAIL busy_before_reset: got req=%b expected 1", req); end
    reset = 1'b1;
    cmd = {1'b1, 7'h06}; sw = 4'hA;
    @(negedge clk);
    checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL midreset_we: got %b expected 0", we); end
    checks++; if (req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req: got %b expected 0", req); end
    checks++; if (resp !== 8'h00) begin errors++; $display("[TB] FAIL midreset_resp: got %h expected 00", resp); end
    checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL midreset_halt: got %b expected 0", halt); end
    reset = 1'b0; gnt = 1'b1; toggle = 1'b1;
    addr_m = 16'h0; count_m = 16'h0;
    for (int k = 0; k < 8; k++) mem_m[16'h0200 + k] = vram[16'h0200 + k];
    @(negedge clk);
    checks++; if (resp[7] !== 1'b1) begin errors++; $display("[TB] FAIL held_cmd_ack: got %b expected 1", resp[7]); end
    checks++; if (toice !== 16'h000A) begin errors++; $display("[TB] FAIL read_sw: got %h expected 000a", toice); end
    run_cmd(7'h02, 16'h0, 0, 0);
    checks++; if (addr_c2 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0000", addr_c2); end
    checks++; if (toice !== {13'b0, mem_m[16'h0000]}) begin errors++; $display("[TB] FAIL reset_peek_data: got %h expected %h", toice, {13'b0, mem_m[16'h0000]}); end
`ifdef ICE_FILL_EN
    run_cmd(7'h04, 16'h0002, 0, 0);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL reset_count: got latency %0d expected 1", lat); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      vram[i]  = pat(i);
      mem_m[i] = pat(i);
    end
    test_reset();
    test_set_addr_peek();
    test_poke_peek();
`ifdef ICE_FILL_EN
    test_fill_wrap();
    test_grant_loss(4, 6);
    test_grant_loss(1, 5);
`else
    test_fill_disabled();
`endif
    test_illegal();
    test_halt();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
